// File: rtl/vpi_resp_pkg.sv
// vpi_resp_pkg: opcodes, FSM states and handle/type constants shared by the
// parameter scan responder and its iterator slot table.
package vpi_resp_pkg;
    typedef enum logic [1:0] {OP_ITERATE = 2'd0, OP_SCAN = 2'd1, OP_GET = 2'd2, OP_FREE = 2'd3} op_e;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOOKUP = 2'd1, ST_RESP = 2'd2} state_e;
    localparam logic [7:0] NULL_HANDLE    = 8'd0;
    localparam logic [7:0] ITER_BASE      = 8'h80;
    localparam logic [7:0] TYPE_PARAMETER = 8'd41;
    localparam logic [7:0] TYPE_ITERATOR  = 8'h7F;
endpackage

// File: rtl/param_scan_responder_if.sv
// param_scan_responder_if: request/response handshake between scanner (master) and responder (slave).
interface param_scan_responder_if #(parameter int DATA_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [7:0]        req_handle;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_handle;
    logic [7:0]        rsp_type;
    logic [DATA_W-1:0] rsp_value;
    logic              rsp_err;
    modport master (output req_valid, req_op, req_handle, rsp_ready,
                    input  req_ready, rsp_valid, rsp_handle, rsp_type, rsp_value, rsp_err);
    modport slave  (input  req_valid, req_op, req_handle, rsp_ready,
                    output req_ready, rsp_valid, rsp_handle, rsp_type, rsp_value, rsp_err);
endinterface

// File: rtl/param_iter_slots.sv
// param_iter_slots: iterator slot table (valid bit + saturating 7-bit cursor per slot)
// with lowest-free allocation, lookup, advance and free.
module param_iter_slots #(
    parameter int NUM_PARAMS = 4,
    parameter int MAX_ITERS  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alloc_i,
    input  logic       advance_i,
    input  logic       free_i,
    input  logic [2:0] idx_i,
    output logic       full_o,
    output logic [2:0] alloc_idx_o,
    output logic       hit_o,
    output logic [6:0] cursor_o
);
    logic [7:0] valid_q;
    logic [6:0] cursor_q [8];
    always_comb begin
        alloc_idx_o = 3'd0;
        full_o      = 1'b1;
        for (int i = MAX_ITERS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_idx_o = 3'(i);
                full_o      = 1'b0;
            end
        end
    end
    // slots at or above MAX_ITERS are never allocated, so they never hit
    assign hit_o    = valid_q[idx_i];
    assign cursor_o = cursor_q[idx_i];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < 8; i++) cursor_q[i] <= '0;
        end else begin
            if (alloc_i) begin
                valid_q[alloc_idx_o]  <= 1'b1;
                cursor_q[alloc_idx_o] <= '0;
            end
            if (advance_i && cursor_q[idx_i] < 7'(NUM_PARAMS)) cursor_q[idx_i] <= cursor_q[idx_i] + 7'd1;
            if (free_i) valid_q[idx_i] <= 1'b0;
        end
    end
endmodule

// File: rtl/param_scan_responder.sv
// param_scan_responder: answers iterate/scan/get/free requests about a parameterised
// instance's parameters, vpi_iterate/vpi_scan style (null ends a scan and frees the iterator).
module param_scan_responder
    import vpi_resp_pkg::*;
#(
    parameter int NUM_PARAMS = 4,
    parameter int DATA_W     = 32,
    parameter logic [(NUM_PARAMS > 0 ? NUM_PARAMS : 1)*DATA_W-1:0] PARAM_VALUES =
        {{((NUM_PARAMS > 0 ? NUM_PARAMS : 1)*DATA_W-1){1'b0}}, 1'b1},
    parameter int MAX_ITERS  = 2
) (
    input logic clk,
    input logic rst,
    param_scan_responder_if.slave bus
);
    state_e            state_q, state_d;
    op_e               op_q;
    logic [7:0]        handle_q, rsp_handle_q, rsp_handle_d, rsp_type_q, rsp_type_d;
    logic [DATA_W-1:0] rsp_value_q, rsp_value_d, param_val;
    logic              rsp_err_q, rsp_err_d;
    logic              full, hit, alloc, advance, free, lookup, is_iter, is_param, more;
    logic [2:0]        alloc_idx;
    logic [6:0]        cursor;
    param_iter_slots #(.NUM_PARAMS(NUM_PARAMS), .MAX_ITERS(MAX_ITERS)) u_slots (
        .clk(clk), .rst(rst),
        .alloc_i(lookup && alloc), .advance_i(lookup && advance), .free_i(lookup && free),
        .idx_i(handle_q[2:0]),
        .full_o(full), .alloc_idx_o(alloc_idx), .hit_o(hit), .cursor_o(cursor)
    );
    assign lookup    = state_q == ST_LOOKUP;
    assign is_iter   = handle_q[7] && handle_q[6:3] == 4'd0 && int'(handle_q[2:0]) < MAX_ITERS && hit;
    assign is_param  = handle_q != NULL_HANDLE && int'(handle_q) <= NUM_PARAMS;
    assign more      = int'(cursor) < NUM_PARAMS;
    assign param_val = PARAM_VALUES[(is_param ? int'(handle_q) - 1 : 0)*DATA_W +: DATA_W];
    always_comb begin
        rsp_handle_d = NULL_HANDLE;
        rsp_type_d   = 8'd0;
        rsp_value_d  = '0;
        rsp_err_d    = 1'b0;
        alloc        = 1'b0;
        advance      = 1'b0;
        free         = 1'b0;
        case (op_q)
            OP_ITERATE: if (NUM_PARAMS != 0) begin
                alloc        = !full;
                rsp_err_d    = full;
                rsp_handle_d = full ? NULL_HANDLE : ITER_BASE | {5'd0, alloc_idx};
                rsp_type_d   = full ? 8'd0 : TYPE_ITERATOR;
            end
            OP_SCAN: begin
                advance      = is_iter && more;
                free         = is_iter && !more;
                rsp_err_d    = !is_iter;
                rsp_handle_d = advance ? {1'b0, cursor} + 8'd1 : NULL_HANDLE;
                rsp_type_d   = advance ? TYPE_PARAMETER : 8'd0;
            end
            OP_GET: begin
                rsp_err_d    = !is_param;
                rsp_handle_d = is_param ? handle_q : NULL_HANDLE;
                rsp_type_d   = is_param ? TYPE_PARAMETER : 8'd0;
                rsp_value_d  = is_param ? param_val : '0;
            end
            default: begin
                free      = is_iter;
                rsp_err_d = !is_iter;
            end
        endcase
    end
    always_comb
        state_d = state_q == ST_IDLE   ? (bus.req_valid ? ST_LOOKUP : ST_IDLE) :
                  state_q == ST_LOOKUP ? ST_RESP : (bus.rsp_ready ? ST_IDLE : ST_RESP);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_ITERATE;
            handle_q     <= '0;
            rsp_handle_q <= '0;
            rsp_type_q   <= '0;
            rsp_value_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (bus.req_valid && bus.req_ready) begin
                op_q     <= op_e'(bus.req_op);
                handle_q <= bus.req_handle;
            end
            if (lookup) begin
                rsp_handle_q <= rsp_handle_d;
                rsp_type_q   <= rsp_type_d;
                rsp_value_q  <= rsp_value_d;
                rsp_err_q    <= rsp_err_d;
            end
        end
    end
    assign bus.req_ready  = state_q == ST_IDLE;
    assign bus.rsp_valid  = state_q == ST_RESP;
    assign bus.rsp_handle = rsp_handle_q;
    assign bus.rsp_type   = rsp_type_q;
    assign bus.rsp_value  = rsp_value_q;
    assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_param_scan_responder.sv
// tb_param_scan_responder: directed test-plan scenarios plus randomized traffic against
// a behavioural slot/parameter model, on a default instance and an empty (NUM_PARAMS=0) one.
module tb_param_scan_responder;
    logic       clk = 0, rst = 1;
    logic       req_valid = 0, rsp_ready = 1;
    logic [1:0] req_op = 0;
    logic [7:0] req_handle = 0;
    bit         sel = 0;
    int         checks = 0, failures = 0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [7:0]  rsp_handle, rsp_type;
    logic [31:0] rsp_value;
    param_scan_responder_if #(.DATA_W(32)) a ();
    param_scan_responder_if #(.DATA_W(32)) b ();
    param_scan_responder #(.NUM_PARAMS(4), .DATA_W(32), .MAX_ITERS(2)) dut (.clk(clk), .rst(rst), .bus(a));
    param_scan_responder #(.NUM_PARAMS(0), .DATA_W(32), .MAX_ITERS(2)) dut_empty (.clk(clk), .rst(rst), .bus(b));
    assign a.req_valid = req_valid && !sel;
    assign b.req_valid = req_valid && sel;
    assign a.req_op = req_op;
    assign b.req_op = req_op;
    assign a.req_handle = req_handle;
    assign b.req_handle = req_handle;
    assign a.rsp_ready = rsp_ready;
    assign b.rsp_ready = rsp_ready;
    assign req_ready  = sel ? b.req_ready  : a.req_ready;
    assign rsp_valid  = sel ? b.rsp_valid  : a.rsp_valid;
    assign rsp_handle = sel ? b.rsp_handle : a.rsp_handle;
    assign rsp_type   = sel ? b.rsp_type   : a.rsp_type;
    assign rsp_value  = sel ? b.rsp_value  : a.rsp_value;
    assign rsp_err    = sel ? b.rsp_err    : a.rsp_err;
    always #5 clk = ~clk;
    // model: per DUT, iterator slot valid flags and cursors
    bit          mv [2][2];
    int          mc [2][2];
    logic [31:0] pv [4] = '{32'd1, 32'd0, 32'd0, 32'd0};
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic mreset();
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 2; s++) begin
                mv[d][s] = 0;
                mc[d][s] = 0;
            end
    endtask
    task automatic model(input logic [1:0] op, input logic [7:0] h, output logic [48:0] e);
        int np = sel ? 0 : 4;
        int s = int'(h) - 128;
        bit it = s >= 0 && s < 2 && mv[sel][s];
        logic [7:0] rh = 0, rt = 0;
        logic [31:0] rv = 0;
        logic re = 0;
        case (op)
            2'd0: if (np > 0) begin
                re = 1;
                for (int i = 0; i < 2; i++)
                    if (re && !mv[sel][i]) begin
                        re = 0; mv[sel][i] = 1; mc[sel][i] = 0;
                        rh = 8'(128 + i); rt = 8'h7F;
                    end
            end
            2'd1: if (!it) re = 1;
                  else if (mc[sel][s] < np) begin
                      rh = 8'(mc[sel][s] + 1); rt = 8'd41; mc[sel][s]++;
                  end else mv[sel][s] = 0;
            2'd2: if (h >= 1 && int'(h) <= np) begin
                      rh = h; rt = 8'd41; rv = pv[h - 1];
                  end else re = 1;
            default: if (it) mv[sel][s] = 0; else re = 1;
        endcase
        e = {rh, rt, rv, re};
    endtask
    task automatic issue(input logic [1:0] op, input logic [7:0] h, input logic rdy, output bit ok);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        req_valid = 1; req_op = op; req_handle = h; rsp_ready = rdy;
        @(posedge clk); #1 req_valid = 0;
        n = 0;
        while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
        ok = rsp_valid;
    endtask
    logic [7:0] last_h;
    task automatic txn(input string tag, input logic [1:0] op, input logic [7:0] h, input int stall);
        logic [48:0] e;
        bit ok;
        model(op, h, e);
        issue(op, h, stall == 0, ok);
        if (!ok) check({tag, "_timeout"}, 0, 1);
        else begin
            repeat (stall) @(negedge clk);
            check(tag, {rsp_handle, rsp_type, rsp_value, rsp_err}, e);
        end
        last_h = rsp_handle;
        rsp_ready = 1;
        @(posedge clk); #1;
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        logic [48:0] e;
        bit ok;
        mreset();
        #2;
        check("rst_flags", {req_ready, rsp_valid}, 2'b10);
        check("rst_fields", {rsp_handle, rsp_type, rsp_value, rsp_err}, 0);
        @(negedge clk) rst = 0;
        // full scan
        txn("iter", 0, 8'h00, 0);
        check("iter_handle", last_h, 8'h80);
        for (int i = 0; i < 5; i++) txn($sformatf("scan%0d", i), 1, 8'h80, 0);
        check("scan_end_null", last_h, 8'h00);
        txn("scan_freed", 1, 8'h80, 0);
        // get
        txn("get1", 2, 8'd1, 0);
        txn("get5", 2, 8'd5, 0);
        txn("get0", 2, 8'd0, 0);
        // exhaustion
        txn("ex_it0", 0, 0, 0);
        txn("ex_it1", 0, 0, 0);
        check("ex_it1_handle", last_h, 8'h81);
        txn("ex_it2", 0, 0, 0);
        txn("ex_free", 3, 8'h80, 0);
        txn("ex_realloc", 0, 0, 0);
        check("ex_realloc_handle", last_h, 8'h80);
        txn("ex_free0", 3, 8'h80, 0);
        txn("ex_free1", 3, 8'h81, 0);
        txn("ex_free_again", 3, 8'h81, 0);
        // backpressure
        txn("bp_iter", 0, 0, 0);
        model(1, 8'h80, e);
        issue(1, 8'h80, 0, ok);
        check("bp_valid", rsp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {rsp_handle, rsp_type, rsp_value, rsp_err}, e);
            check("bp_req_ready", req_ready, 0);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        check("bp_done", {req_ready, rsp_valid}, 2'b10);
        // reset during LOOKUP
        txn("rm_scan", 1, 8'h80, 0);
        @(negedge clk);
        req_valid = 1; req_op = 1; req_handle = 8'h80;
        @(posedge clk); #1 req_valid = 0;
        rst = 1;
        #1;
        check("rm_valid", rsp_valid, 0);
        check("rm_ready", req_ready, 1);
        mreset();
        @(negedge clk) rst = 0;
        @(posedge clk); #1;
        check("rm_after", {req_ready, rsp_valid}, 2'b10);
        txn("rm_scan_after", 1, 8'h80, 0);
        // reset while a response is being held
        txn("ad_iter", 0, 0, 0);
        issue(1, 8'h80, 0, ok);
        check("ad_valid_pre", rsp_valid, 1);
        #2 rst = 1;
        #1 check("ad_valid_drop", rsp_valid, 0);
        mreset();
        @(negedge clk) rst = 0;
        rsp_ready = 1;
        txn("ad_scan_after", 1, 8'h80, 0);
        // empty module
        sel = 1;
        txn("empty_iter", 0, 0, 0);
        txn("empty_scan", 1, 8'h80, 0);
        txn("empty_get1", 2, 8'd1, 0);
        sel = 0;
        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [7:0] h;
            int stall;
            sel = $urandom_range(0, 7) == 0;
            case ($urandom_range(0, 3))
                0: h = 8'($urandom_range(0, 6));
                1: h = 8'($urandom_range(128, 131));
                2: h = 8'h80;
                default: h = 8'($urandom);
            endcase
            stall = $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0;
            txn($sformatf("rnd%0d", n), 2'($urandom_range(0, 3)), h, stall);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
